// File: rtl/pc_flow_unit.sv
// Program-flow stage: status register, 20-bit PC, jumps and trap/resume handling.
// Latency: one cycle from an accepted op to pc/status/taken; every output is registered.
// Backpressure: stall freezes all state, except the single TRAP_ENTRY cycle, which always advances to HALT.
module pc_flow_unit #(
    parameter int                 ADDR_W   = 20,
    parameter logic [ADDR_W-1:0]  RESET_PC = 20'h00000,
    parameter logic [ADDR_W-1:0]  TRAP_VEC = 20'h00010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              stall,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] target,
    input  logic [2:0]        sr_in,
    input  logic              alu_zero,
    input  logic              alu_sign,
    input  logic              alu_carry,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        status,
    output logic              taken,
    output logic              trapped,
    output logic [ADDR_W-1:0] epc
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        TRAP_ENTRY = 2'd1,
        HALT       = 2'd2
    } state_t;

    typedef struct packed {
        logic carry;
        logic sign;
        logic zero;
    } sr_t;

    localparam logic [3:0] OP_TRAP = 4'd1;
    localparam logic [3:0] OP_JMP  = 4'd2;
    localparam logic [3:0] OP_JZ   = 4'd3;
    localparam logic [3:0] OP_JS   = 4'd4;
    localparam logic [3:0] OP_JZS  = 4'd5;
    localparam logic [3:0] OP_LSR  = 4'd6;
    localparam logic [3:0] OP_XSR  = 4'd7;
    localparam logic [3:0] OP_ALU  = 4'd8;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d, pc_inc;
    sr_t               status_q, status_d;
    logic              taken_q, taken_d;
    logic              trapped_q;
    logic              jump_cond;

    assign pc_inc = pc_q + ADDR_W'(1);

    // Jump conditions use the registered flags only, never the same-cycle ALU flags.
    always_comb begin
        jump_cond = 1'b0;
        case (op)
            OP_JMP:  jump_cond = 1'b1;
            OP_JZ:   jump_cond = status_q.zero;
            OP_JS:   jump_cond = status_q.sign;
            OP_JZS:  jump_cond = status_q.zero | status_q.sign;
            default: jump_cond = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        status_d = status_q;
        epc_d    = epc_q;
        taken_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (valid_in && !stall) begin
                    pc_d = pc_inc;
                    case (op)
                        OP_TRAP: begin
                            epc_d   = pc_inc;
                            pc_d    = TRAP_VEC;
                            taken_d = 1'b1;
                            state_d = TRAP_ENTRY;
                        end
                        OP_JMP, OP_JZ, OP_JS, OP_JZS: begin
                            if (jump_cond) begin
                                pc_d    = target;
                                taken_d = 1'b1;
                            end
                        end
                        OP_LSR:  status_d = sr_t'(sr_in);
                        OP_XSR:  status_d = sr_t'(status_q ^ sr_in);
                        OP_ALU:  status_d = sr_t'({alu_carry, alu_sign, alu_zero});
                        default: ;
                    endcase
                end
            end
            TRAP_ENTRY: state_d = HALT;
            HALT: begin
                if (resume && !stall) begin
                    pc_d    = epc_q;
                    taken_d = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            status_q  <= '0;
            epc_q     <= '0;
            taken_q   <= 1'b0;
            trapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            status_q  <= status_d;
            epc_q     <= epc_d;
            taken_q   <= taken_d;
            trapped_q <= (state_d == HALT);
        end
    end

    assign pc      = pc_q;
    assign status  = status_q;
    assign taken   = taken_q;
    assign trapped = trapped_q;
    assign epc     = epc_q;

endmodule

// File: tb/tb_pc_flow_unit.sv
// Bench for pc_flow_unit: directed vector table followed by randomized traffic
// compared against a behavioural model of the flow rules.
module tb_pc_flow_unit;

    localparam logic [19:0] RESET_PC = 20'h00000;
    localparam logic [19:0] TRAP_VEC = 20'h00010;

    logic        clk = 1'b0;
    logic        rst, valid_in, stall, alu_zero, alu_sign, alu_carry, resume;
    logic [3:0]  op;
    logic [19:0] target;
    logic [2:0]  sr_in;
    logic [19:0] pc, epc;
    logic [2:0]  status;
    logic        taken, trapped;

    pc_flow_unit #(.ADDR_W(20), .RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .op(op),
        .target(target), .sr_in(sr_in), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .alu_carry(alu_carry), .resume(resume), .pc(pc), .status(status),
        .taken(taken), .trapped(trapped), .epc(epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst, valid, stall;
        bit [3:0]  op;
        bit [19:0] target;
        bit [2:0]  sr;
        bit [2:0]  csz;
        bit        resume;
        bit [19:0] e_pc;
        bit [2:0]  e_st;
        bit        e_tk, e_tr;
        bit [19:0] e_epc;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: mode 0 = running, 1 = entering trap, 2 = halted.
    int          m_mode = 0;
    logic [19:0] m_pc = '0, m_epc = '0;
    logic [2:0]  m_st = '0;
    logic        m_tk = 1'b0, m_tr = 1'b0;

    function automatic vec_t mk(int r, int v, int s, int o, int t, int sr, int csz, int res,
                                int epc_pc, int est, int etk, int etr, int eepc);
        vec_t x;
        x.rst = r[0]; x.valid = v[0]; x.stall = s[0]; x.op = o[3:0];
        x.target = t[19:0]; x.sr = sr[2:0]; x.csz = csz[2:0]; x.resume = res[0];
        x.e_pc = epc_pc[19:0]; x.e_st = est[2:0]; x.e_tk = etk[0]; x.e_tr = etr[0];
        x.e_epc = eepc[19:0];
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input vec_t v);
        logic cond;
        m_tk = 1'b0;
        if (v.rst) begin
            m_mode = 0; m_pc = RESET_PC; m_st = '0; m_epc = '0;
        end else if (m_mode == 1) begin
            m_mode = 2;
        end else if (m_mode == 2) begin
            if (v.resume && !v.stall) begin
                m_pc = m_epc; m_tk = 1'b1; m_mode = 0;
            end
        end else if (v.valid && !v.stall) begin
            if (v.op == 1) begin
                m_epc = m_pc + 20'd1; m_pc = TRAP_VEC; m_tk = 1'b1; m_mode = 1;
            end else if (v.op >= 2 && v.op <= 5) begin
                cond = (v.op == 2) || (v.op == 3 && m_st[0]) || (v.op == 4 && m_st[1]) ||
                       (v.op == 5 && (m_st[0] || m_st[1]));
                m_pc = cond ? v.target : m_pc + 20'd1;
                m_tk = cond;
            end else begin
                if (v.op == 6) m_st = v.sr;
                if (v.op == 7) m_st = m_st ^ v.sr;
                if (v.op == 8) m_st = v.csz;
                m_pc = m_pc + 20'd1;
            end
        end
        m_tr = (m_mode == 2);
    endtask

    task automatic drive_cycle(input vec_t v);
        rst = v.rst; valid_in = v.valid; stall = v.stall; op = v.op; target = v.target;
        sr_in = v.sr; alu_carry = v.csz[2]; alu_sign = v.csz[1]; alu_zero = v.csz[0];
        resume = v.resume;
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[28];
    vec_t rv;

    initial begin
        rst = 1'b1; valid_in = 0; stall = 0; op = '0; target = '0; sr_in = '0;
        alu_zero = 0; alu_sign = 0; alu_carry = 0; resume = 0;

        //            rst v  s  op target  sr   csz res   pc       st   tk tr epc
        tbl[0]  = mk(1, 0, 0, 0, 0,       0,   0,  0,    'h0,     0,   0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 8, 0,       0,   1,  0,    'h1,     1,   0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 8, 0,       0,   1,  0,    'h2,     1,   0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 8, 0,       0,   1,  0,    'h3,     1,   0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 3, 'h400,   0,   6,  0,    'h400,   1,   1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 2, 'h55,    0,   0,  0,    'h400,   1,   0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 6, 0,       0,   0,  0,    'h401,   0,   0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 3, 'h123,   0,   1,  0,    'h402,   0,   0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 6, 0,       5,   0,  0,    'h403,   5,   0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 7, 0,       6,   0,  0,    'h404,   3,   0, 0, 0);
        tbl[10] = mk(0, 1, 1, 2, 0,       0,   0,  0,    'h404,   3,   0, 0, 0);
        tbl[11] = mk(0, 1, 0, 6, 0,       2,   0,  0,    'h405,   2,   0, 0, 0);
        tbl[12] = mk(0, 1, 0, 5, 'h777,   0,   0,  0,    'h777,   2,   1, 0, 0);
        tbl[13] = mk(0, 1, 0, 6, 0,       1,   0,  0,    'h778,   1,   0, 0, 0);
        tbl[14] = mk(0, 1, 0, 4, 'h999,   0,   2,  0,    'h779,   1,   0, 0, 0);
        tbl[15] = mk(0, 1, 0, 2, 'h20,    0,   0,  0,    'h20,    1,   1, 0, 0);
        tbl[16] = mk(0, 1, 0, 1, 0,       0,   0,  0,    'h10,    1,   1, 0, 'h21);
        tbl[17] = mk(0, 1, 0, 2, 5,       0,   0,  1,    'h10,    1,   0, 1, 'h21);
        tbl[18] = mk(0, 1, 0, 8, 0,       0,   6,  0,    'h10,    1,   0, 1, 'h21);
        tbl[19] = mk(0, 0, 1, 0, 0,       0,   0,  1,    'h10,    1,   0, 1, 'h21);
        tbl[20] = mk(0, 0, 0, 0, 0,       0,   0,  1,    'h21,    1,   1, 0, 'h21);
        tbl[21] = mk(0, 1, 0, 0, 0,       0,   0,  0,    'h22,    1,   0, 0, 'h21);
        tbl[22] = mk(0, 1, 0, 1, 0,       0,   0,  0,    'h10,    1,   1, 0, 'h23);
        tbl[23] = mk(0, 1, 0, 0, 0,       0,   0,  0,    'h10,    1,   0, 1, 'h23);
        tbl[24] = mk(1, 1, 0, 2, 'h300,   0,   0,  1,    'h0,     0,   0, 0, 0);
        tbl[25] = mk(0, 1, 0, 2, 'hFFFFF, 0,   0,  0,    'hFFFFF, 0,   1, 0, 0);
        tbl[26] = mk(0, 1, 0, 0, 0,       0,   0,  0,    'h0,     0,   0, 0, 0);
        tbl[27] = mk(0, 1, 0, 12, 'h44,   7,   7,  0,    'h1,     0,   0, 0, 0);

        for (int i = 0; i < 28; i++) begin
            drive_cycle(tbl[i]);
            chk($sformatf("v%0d.pc", i),      32'(pc),      32'(tbl[i].e_pc));
            chk($sformatf("v%0d.status", i),  32'(status),  32'(tbl[i].e_st));
            chk($sformatf("v%0d.taken", i),   32'(taken),   32'(tbl[i].e_tk));
            chk($sformatf("v%0d.trapped", i), 32'(trapped), 32'(tbl[i].e_tr));
            chk($sformatf("v%0d.epc", i),     32'(epc),     32'(tbl[i].e_epc));
        end

        // Randomized traffic; jump targets near the top of the address space exercise wrap.
        for (int i = 0; i < 3000; i++) begin
            rv = mk(($urandom_range(0, 99) == 0) ? 1 : 0,
                    ($urandom_range(0, 3) != 0) ? 1 : 0,
                    ($urandom_range(0, 4) == 0) ? 1 : 0,
                    int'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(20'hFFFF0, 20'hFFFFF))
                                                : int'($urandom_range(0, 20'hFFFFF)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? 1 : 0,
                    0, 0, 0, 0, 0);
            drive_cycle(rv);
            chk("rnd.pc",      32'(pc),      32'(m_pc));
            chk("rnd.status",  32'(status),  32'(m_st));
            chk("rnd.taken",   32'(taken),   32'(m_tk));
            chk("rnd.trapped", 32'(trapped), 32'(m_tr));
            chk("rnd.epc",     32'(epc),     32'(m_epc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
